fpc_rr_tag_alloc: RTL and testbench
===================================

# fpc_rr_tag_alloc

Per-channel PCIe read-request tag allocator for the HIFIFO from-PC (fpc) path. It hands out the low tag bits that accompany each channel's read request into the read-request multiplexer. It marks each tag outstanding until the final completion for that tag returns, and it throttles a channel when its tag ring is exhausted. Tags are issued in strict ring order per channel, so completion data can be reassembled in request order downstream.

## Interface
- NBITS_TAG_LOW, 3: low tag bits per channel; ring depth D = 2**NBITS_TAG_LOW.
- ENABLE, 4'b0001: channel enable mask; disabled channels never assert rr_valid and own no state.
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- rr_valid  out  4  per channel: a free tag is offered.
- rr_ready  in  4  per channel: request accepted; the offered tag becomes outstanding.
- rr_tag_low  out  4*NBITS_TAG_LOW  per channel offered tag; channel i occupies bits [(i+1)*N-1 : i*N].
- c_valid  in  1  completion beat valid.
- c_last  in  1  beat is the final completion for its tag.
- c_tag  in  8  completion tag {2'b0, ch[1:0], 1'b0, low[2:0]}.
- ch_flush  in  4  per channel abort: clear all outstanding tags and rewind the ring.
- outstanding  out  4*(NBITS_TAG_LOW+1)  per channel count of busy tags, range 0..D.
- err_bad_tag  out  1  sticky: a completion was ignored.

## Operation
- State per enabled channel i:
  - busy[i], D bits.
  - next[i], NBITS_TAG_LOW bits, wraps D-1 -> 0.
  - outstanding count, NBITS_TAG_LOW+1 bits.
- Offer logic, combinational from registers only:
  - rr_valid[i] = ENABLE[i] & ~busy[i][next[i]].
  - rr_tag_low[i] = next[i].
- Allocate on rr_valid[i] & rr_ready[i]:
  - set busy[i][next[i]].
  - next[i] <= next[i]+1, modulo D.
  - count +1.
  - rr_ready while rr_valid is low has no effect.
- Free on c_valid & c_last with a valid tag: clear busy[ch][low] and count -1.
  - Non-last beats change no state.
- Out-of-order free is allowed, but allocation stays in ring order. If next[i] is still busy, the channel stalls even when other tags are free.
- A completion is bad, and is ignored with err_bad_tag set, when c_valid & c_last and any of the following holds:
  - c_tag[7:6] != 0.
  - c_tag[3] != 0.
  - the channel is disabled.
  - low >= D.
  - the tag is not busy.
- Simultaneous allocate and free on the same channel (necessarily different tags): both apply and the count is unchanged.
- ch_flush[i] takes priority over allocate and free in the same cycle:
  - busy[i] <= 0, next[i] <= 0, count <= 0.
  - A completion for a flushed tag arriving later sets err_bad_tag.
- err_bad_tag clears only on reset.

## Timing
- Reset values:
  - busy = 0, next = 0, outstanding = 0, err_bad_tag = 0.
  - rr_valid = ENABLE, so offers begin in the cycle after reset deasserts.
  - rr_tag_low = 0.
- Reset mid-operation discards all outstanding tags and is identical to power-up.
- Allocation handshake at edge E:
  - next and count update at E.
  - the new rr_valid and rr_tag_low are visible after E. Back-to-back allocation at one per cycle is sustained while tags are free.
- Free at edge E: rr_valid can reassert in the cycle after E. Latency from c_last to re-offer is one cycle; there is no combinational path from c_* to rr_*.
- Flush at edge E: rr_valid[i] = 1 with tag 0 after E.
- Full: after D allocations with no frees, rr_valid[i] = 0 and outstanding = D (4'd8 for N=3).

## Test plan
- Reset, ENABLE=4'b0001 -> rr_valid=4'b0001, rr_tag_low[2:0]=0, outstanding=0, err_bad_tag=0; channels 1-3 never assert rr_valid even with rr_ready=4'hF.
- rr_ready[0] held high for 10 cycles -> tags 0..7 accepted on consecutive cycles, then rr_valid[0]=0, outstanding[3:0]=8.
- Ring full; completion c_tag=8'h03 with c_last -> rr_valid[0] stays 0 (next=0 busy), outstanding=7. Then completion c_tag=8'h00 -> rr_valid[0]=1 with tag 0 the next cycle.
- Allocate tag 5 and complete tag 2 in the same cycle -> busy bit 5 set, busy bit 2 cleared, outstanding unchanged. A non-last beat on tag 4 -> no change.
- Bad completions (c_tag=8'h40, 8'h08, 8'h10 on a disabled channel, and 8'h06 when tag 6 is free) -> state unchanged, err_bad_tag=1, held until reset.
- With 5 tags outstanding, pulse ch_flush[0] together with rr_ready[0] and a valid completion -> outstanding=0, rr_valid[0]=1 with tag 0. A later completion for an old tag -> err_bad_tag=1.

Source files
------------

// File: rtl/fpc_rr_tag_alloc.sv
// fpc_rr_tag_alloc: per-channel read-request tag allocator for the HIFIFO
// from-PC path. Each enabled channel owns a ring of D = 2**NBITS_TAG_LOW tags.
// Tags are offered strictly in ring order and stay busy until the final
// completion beat for that tag returns.
//
// Handshake: rr_valid[i] is asserted whenever the ring slot at next[i] is
// free and depends only on registers. A tag is consumed on any rising clock
// edge where rr_valid[i] & rr_ready[i]. rr_ready[i] has no effect while
// rr_valid[i] is low. Completions are single-cycle pulses qualified by c_valid;
// only beats with c_last free a tag. No combinational path runs from the c_*
// inputs to the rr_* outputs.
module fpc_rr_tag_alloc #(
  parameter int         NBITS_TAG_LOW = 3,
  parameter logic [3:0] ENABLE        = 4'b0001
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic [3:0]                     rr_valid,
  input  logic [3:0]                     rr_ready,
  output logic [4*NBITS_TAG_LOW-1:0]     rr_tag_low,
  input  logic                           c_valid,
  input  logic                           c_last,
  input  logic [7:0]                     c_tag,
  input  logic [3:0]                     ch_flush,
  output logic [4*(NBITS_TAG_LOW+1)-1:0] outstanding,
  output logic                           err_bad_tag
);

  localparam int N = NBITS_TAG_LOW;
  localparam int D = 1 << N;

  localparam logic [N-1:0] ONE_TAG = 1;
  localparam logic [N:0]   ONE_CNT = 1;

  // Completion tag decode: {2'b0, ch[1:0], 1'b0, low[2:0]}
  logic       c_fin;
  logic       c_fmt_ok;
  logic       c_low_ok;
  logic [1:0] c_ch;
  logic [2:0] c_low;
  logic [3:0] free_ok;
  logic       bad_cpl;
  logic       err_bad_tag_q;

  assign c_fin    = c_valid & c_last;
  assign c_ch     = c_tag[5:4];
  assign c_low    = c_tag[2:0];
  assign c_fmt_ok = (c_tag[7:6] == 2'b00) & ~c_tag[3];
  assign c_low_ok = (32'(c_low) < 32'(D));

  // A final beat that no enabled channel accepts as a busy tag is bad.
  assign bad_cpl = c_fin & ~(|free_ok);

  // Disabled channels leave some input bits without a consumer.
  logic unused_inputs;
  assign unused_inputs = ^{rr_ready, ch_flush};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    if (ENABLE[i]) begin : g_on
      logic [D-1:0] busy_q, busy_d;
      logic [N-1:0] next_q, next_d;
      logic [N:0]   cnt_q, cnt_d;
      logic         offer;
      logic         alloc;
      logic         free;

      assign offer      = ~busy_q[next_q];
      assign alloc      = offer & rr_ready[i];
      assign free       = c_fin & c_fmt_ok & c_low_ok & (c_ch == 2'(i)) & busy_q[c_low];
      assign free_ok[i] = free;

      // Next-state: flush wins over allocate and free; allocate and free on
      // the same cycle always touch different tags, so both apply.
      always_comb begin
        busy_d = busy_q;
        next_d = next_q;
        cnt_d  = cnt_q;
        if (ch_flush[i]) begin
          busy_d = '0;
          next_d = '0;
          cnt_d  = '0;
        end else begin
          if (alloc) begin
            busy_d[next_q] = 1'b1;
            next_d         = next_q + ONE_TAG;
          end
          if (free) begin
            busy_d[c_low] = 1'b0;
          end
          case ({alloc, free})
            2'b10:   cnt_d = cnt_q + ONE_CNT;
            2'b01:   cnt_d = cnt_q - ONE_CNT;
            default: cnt_d = cnt_q;
          endcase
        end
      end

      // Per-channel ring state registers.
      always_ff @(posedge clock) begin
        if (reset) begin
          busy_q <= '0;
          next_q <= '0;
          cnt_q  <= '0;
        end else begin
          busy_q <= busy_d;
          next_q <= next_d;
          cnt_q  <= cnt_d;
        end
      end

      assign rr_valid[i]                 = offer;
      assign rr_tag_low[i*N +: N]        = next_q;
      assign outstanding[i*(N+1) +: N+1] = cnt_q;
    end else begin : g_off
      assign rr_valid[i]                 = 1'b0;
      assign rr_tag_low[i*N +: N]        = '0;
      assign outstanding[i*(N+1) +: N+1] = '0;
      assign free_ok[i]                  = 1'b0;
    end
  end

  // Sticky bad-completion flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_bad_tag_q <= 1'b0;
    end else if (bad_cpl) begin
      err_bad_tag_q <= 1'b1;
    end
  end

  assign err_bad_tag = err_bad_tag_q;

endmodule

// File: tb/tb_fpc_rr_tag_alloc.sv
// tb_fpc_rr_tag_alloc: directed bench for fpc_rr_tag_alloc (N=3, channel 0 only).
module tb_fpc_rr_tag_alloc;

  localparam int N = 3;

  logic        clock;
  logic        reset;
  logic [3:0]  rr_valid;
  logic [3:0]  rr_ready;
  logic [11:0] rr_tag_low;
  logic        c_valid;
  logic        c_last;
  logic [7:0]  c_tag;
  logic [3:0]  ch_flush;
  logic [15:0] outstanding;
  logic        err_bad_tag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_q[$];

  fpc_rr_tag_alloc #(.NBITS_TAG_LOW(N), .ENABLE(4'b0001)) dut (
    .clock      (clock),
    .reset      (reset),
    .rr_valid   (rr_valid),
    .rr_ready   (rr_ready),
    .rr_tag_low (rr_tag_low),
    .c_valid    (c_valid),
    .c_last     (c_last),
    .c_tag      (c_tag),
    .ch_flush   (ch_flush),
    .outstanding(outstanding),
    .err_bad_tag(err_bad_tag)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Single-cycle completion beat.
  task automatic cpl(input logic [7:0] tag, input logic last);
    c_valid = 1'b1;
    c_last  = last;
    c_tag   = tag;
    step();
    c_valid = 1'b0;
    c_last  = 1'b0;
    c_tag   = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (rr_valid !== 4'b0001) begin
      n_fail++; $display("FAIL reset_rr_valid got=%b exp=%b", rr_valid, 4'b0001);
    end
    n_checks++;
    if (rr_tag_low[2:0] !== 3'd0) begin
      n_fail++; $display("FAIL reset_tag got=%0d exp=0", rr_tag_low[2:0]);
    end
    n_checks++;
    if (outstanding !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outstanding got=%h exp=0000", outstanding);
    end
    n_checks++;
    if (err_bad_tag !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got=%b exp=0", err_bad_tag);
    end
    // Disabled channels stay silent even when ready is offered.
    rr_ready = 4'hE;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (rr_valid !== 4'b0001) begin
        n_fail++; $display("FAIL disabled_ch_valid cyc=%0d got=%b exp=0001", k, rr_valid);
      end
    end
    n_checks++;
    if (outstanding !== 16'h0000) begin
      n_fail++; $display("FAIL disabled_ch_outstanding got=%h exp=0000", outstanding);
    end
    rr_ready = 4'h0;
  endtask

  task automatic test_fill();
    int accepted;
    accepted = 0;
    exp_q.delete();
    for (int t = 0; t < 8; t++) exp_q.push_back(N'(t));
    rr_ready = 4'h1;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (rr_valid[0] !== (k < 8)) begin
        n_fail++; $display("FAIL fill_valid cyc=%0d got=%b exp=%b", k, rr_valid[0], (k < 8));
      end
      if (rr_valid[0] === 1'b1 && exp_q.size() > 0) begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (rr_tag_low[2:0] !== e) begin
          n_fail++; $display("FAIL fill_tag cyc=%0d got=%0d exp=%0d", k, rr_tag_low[2:0], e);
        end
        accepted++;
      end
      step();
    end
    rr_ready = 4'h0;
    n_checks++;
    if (accepted != 8) begin
      n_fail++; $display("FAIL fill_count got=%0d exp=8", accepted);
    end
    n_checks++;
    if (outstanding[3:0] !== 4'd8) begin
      n_fail++; $display("FAIL fill_outstanding got=%0d exp=8", outstanding[3:0]);
    end
    n_checks++;
    if (rr_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL fill_full_valid got=%b exp=0", rr_valid[0]);
    end
  endtask

  task automatic test_full_free();
    cpl(8'h03, 1'b1);
    n_checks++;
    if (rr_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL ooo_free_stall got=%b exp=0", rr_valid[0]);
    end
    n_checks++;
    if (outstanding[3:0] !== 4'd7) begin
      n_fail++; $display("FAIL ooo_free_count got=%0d exp=7", outstanding[3:0]);
    end
    cpl(8'h00, 1'b1);
    n_checks++;
    if (rr_valid[0] !== 1'b1 || rr_tag_low[2:0] !== 3'd0) begin
      n_fail++; $display("FAIL reoffer_tag0 got_v=%b got_t=%0d exp_v=1 exp_t=0", rr_valid[0], rr_tag_low[2:0]);
    end
    n_checks++;
    if (outstanding[3:0] !== 4'd6) begin
      n_fail++; $display("FAIL reoffer_count got=%0d exp=6", outstanding[3:0]);
    end
  endtask

  task automatic test_simul_alloc_free();
    // busy = {1,2,4,5,6,7}; free 1,2,4,5 so tags 0..4 can be taken in order.
    cpl(8'h01, 1'b1);
    cpl(8'h02, 1'b1);
    cpl(8'h04, 1'b1);
    cpl(8'h05, 1'b1);
    n_checks++;
    if (outstanding[3:0] !== 4'd2) begin
      n_fail++; $display("FAIL prep_count got=%0d exp=2", outstanding[3:0]);
    end
    rr_ready = 4'h1;
    for (int k = 0; k < 5; k++) step();
    rr_ready = 4'h0;
    n_checks++;
    if (rr_valid[0] !== 1'b1 || rr_tag_low[2:0] !== 3'd5 || outstanding[3:0] !== 4'd7) begin
      n_fail++; $display("FAIL prep_tag5 got_v=%b got_t=%0d got_n=%0d exp_v=1 exp_t=5 exp_n=7",
                         rr_valid[0], rr_tag_low[2:0], outstanding[3:0]);
    end
    // Allocate tag 5 while tag 2 completes.
    rr_ready = 4'h1;
    c_valid = 1'b1; c_last = 1'b1; c_tag = 8'h02;
    step();
    rr_ready = 4'h0;
    c_valid = 1'b0; c_last = 1'b0; c_tag = 8'h00;
    n_checks++;
    if (outstanding[3:0] !== 4'd7) begin
      n_fail++; $display("FAIL simul_count got=%0d exp=7", outstanding[3:0]);
    end
    n_checks++;
    if (rr_tag_low[2:0] !== 3'd6 || rr_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL simul_next got_t=%0d got_v=%b exp_t=6 exp_v=0", rr_tag_low[2:0], rr_valid[0]);
    end
    // Non-last beat on tag 4 changes nothing.
    cpl(8'h04, 1'b0);
    n_checks++;
    if (outstanding[3:0] !== 4'd7 || err_bad_tag !== 1'b0) begin
      n_fail++; $display("FAIL nonlast_beat got_n=%0d got_e=%b exp_n=7 exp_e=0", outstanding[3:0], err_bad_tag);
    end
    // Tag 5 must now be busy: its completion is accepted.
    cpl(8'h05, 1'b1);
    n_checks++;
    if (outstanding[3:0] !== 4'd6 || err_bad_tag !== 1'b0) begin
      n_fail++; $display("FAIL tag5_busy got_n=%0d got_e=%b exp_n=6 exp_e=0", outstanding[3:0], err_bad_tag);
    end
  endtask

  task automatic test_bad_completions();
    // Busy now {0,1,3,4,6,7}, count 6. Bad tags alias busy tag 0 where possible.
    cpl(8'h40, 1'b1);
    n_checks++;
    if (err_bad_tag !== 1'b1) begin
      n_fail++; $display("FAIL bad_hi_bits_err got=%b exp=1", err_bad_tag);
    end
    n_checks++;
    if (outstanding[3:0] !== 4'd6) begin
      n_fail++; $display("FAIL bad_hi_bits_count got=%0d exp=6", outstanding[3:0]);
    end
    cpl(8'h08, 1'b1);
    n_checks++;
    if (outstanding[3:0] !== 4'd6) begin
      n_fail++; $display("FAIL bad_bit3_count got=%0d exp=6", outstanding[3:0]);
    end
    cpl(8'h10, 1'b1);
    n_checks++;
    if (outstanding[3:0] !== 4'd6 || outstanding[15:4] !== 12'h000) begin
      n_fail++; $display("FAIL bad_disabled_ch got=%h exp=0006", outstanding);
    end
    cpl(8'h02, 1'b1);
    n_checks++;
    if (outstanding[3:0] !== 4'd6) begin
      n_fail++; $display("FAIL bad_free_tag_count got=%0d exp=6", outstanding[3:0]);
    end
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (err_bad_tag !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got=%b exp=1", err_bad_tag);
    end
    // Bad completions must not have disturbed the ring pointer or offer.
    n_checks++;
    if (rr_tag_low[2:0] !== 3'd6 || rr_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL bad_ring_state got_t=%0d got_v=%b exp_t=6 exp_v=0", rr_tag_low[2:0], rr_valid[0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    n_checks++;
    if (err_bad_tag !== 1'b0) begin
      n_fail++; $display("FAIL reset_clears_err got=%b exp=0", err_bad_tag);
    end
    rr_ready = 4'h1;
    for (int k = 0; k < 5; k++) step();
    rr_ready = 4'h0;
    n_checks++;
    if (outstanding[3:0] !== 4'd5 || rr_tag_low[2:0] !== 3'd5) begin
      n_fail++; $display("FAIL back_to_back5 got_n=%0d got_t=%0d exp_n=5 exp_t=5", outstanding[3:0], rr_tag_low[2:0]);
    end
    // Flush together with an allocate and a valid completion.
    ch_flush = 4'h1;
    rr_ready = 4'h1;
    c_valid = 1'b1; c_last = 1'b1; c_tag = 8'h01;
    step();
    ch_flush = 4'h0;
    rr_ready = 4'h0;
    c_valid = 1'b0; c_last = 1'b0; c_tag = 8'h00;
    n_checks++;
    if (outstanding[3:0] !== 4'd0) begin
      n_fail++; $display("FAIL flush_count got=%0d exp=0", outstanding[3:0]);
    end
    n_checks++;
    if (rr_valid[0] !== 1'b1 || rr_tag_low[2:0] !== 3'd0) begin
      n_fail++; $display("FAIL flush_offer got_v=%b got_t=%0d exp_v=1 exp_t=0", rr_valid[0], rr_tag_low[2:0]);
    end
    n_checks++;
    if (err_bad_tag !== 1'b0) begin
      n_fail++; $display("FAIL flush_cpl_err got=%b exp=0", err_bad_tag);
    end
    cpl(8'h03, 1'b1);
    n_checks++;
    if (err_bad_tag !== 1'b1 || outstanding[3:0] !== 4'd0) begin
      n_fail++; $display("FAIL stale_cpl got_e=%b got_n=%0d exp_e=1 exp_n=0", err_bad_tag, outstanding[3:0]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rr_ready = 4'h0;
    c_valid  = 1'b0;
    c_last   = 1'b0;
    c_tag    = 8'h00;
    ch_flush = 4'h0;
    test_reset();
    test_fill();
    test_full_free();
    test_simul_alloc_free();
    test_bad_completions();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
